// File: rtl/ultra_meas_ctrl.sv
// ----------------------------------------------------------------------------
// ultra_meas_ctrl
//
// Measurement sequencer for an HC-SR04-style ultrasonic ranger. The block
// issues one trigger pulse and waits for the echo to rise. It then times the
// echo high width in whole centimetres. After each attempt it holds off
// before the next trigger, which gives the sensor time to settle. Results go
// to the display/BCD stage as a binary distance and a status code.
//
// Ports
//   clk      in   system clock (27 MHz)
//   rst      in   asynchronous active-high reset
//   start    in   one-shot request, honoured in IDLE only
//   cont_en  in   continuous mode: IDLE re-triggers automatically while high
//   abort    in   synchronous abort of the sequence in progress
//   echo     in   raw sensor echo pin (asynchronous to clk)
//   trig     out  registered sensor trigger
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse at the end of every measurement attempt
//   err      out  status captured with done: 00 OK, 01 NO_ECHO, 10 OVER_RANGE
//   dist_cm  out  last distance in cm, held until the next update
// ----------------------------------------------------------------------------
module ultra_meas_ctrl #(
    parameter int TRIG_CYC    = 270,
    parameter int CM_CYCLES   = 1566,
    parameter int RISE_TO     = 810000,
    parameter int MAX_CM      = 400,
    parameter int HOLDOFF_CYC = 1620000,
    parameter int DW          = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cont_en,
    input  logic          abort,
    input  logic          echo,
    output logic          trig,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err,
    output logic [DW-1:0] dist_cm
);

    // One state timer is shared by TRIG, WAIT_RISE and HOLDOFF, because only
    // one of these states is active at a time. It is sized for the longest
    // count among the three.
    localparam int TMR_MAX = (TRIG_CYC > RISE_TO)
                           ? ((TRIG_CYC > HOLDOFF_CYC) ? TRIG_CYC : HOLDOFF_CYC)
                           : ((RISE_TO  > HOLDOFF_CYC) ? RISE_TO  : HOLDOFF_CYC);
    localparam int TW = (TMR_MAX   > 1) ? $clog2(TMR_MAX)   : 1;
    localparam int PW = (CM_CYCLES > 1) ? $clog2(CM_CYCLES) : 1;
    localparam int CW = $clog2(MAX_CM + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_HOLDOFF
    } state_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_NO_ECHO  = 2'b01,
        ST_OVER     = 2'b10
    } status_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tmr_q,   tmr_d;
    logic [PW-1:0]   pre_q,   pre_d;
    logic [CW-1:0]   cm_q,    cm_d;
    logic            trig_q,  trig_d;
    logic            done_q,  done_d;
    status_e         err_q,   err_d;
    logic [DW-1:0]   dist_q,  dist_d;

    logic            echo_meta_q, echo_s_q, echo_d_q;
    logic            fall_q,      fall_d;
    logic            echo_rise;
    logic            pre_wrap;

    // Echo path. The rise edge is used directly from the edge detector. The
    // fall edge goes through one more register. This makes the number of
    // prescaler ticks in MEASURE equal to the echo high width. It also gives
    // a fixed 4-cycle delay from echo fall to done: 2 sync, 1 edge, 1 output.
    assign echo_rise = echo_s_q & ~echo_d_q;
    assign fall_d    = ~echo_s_q & echo_d_q;
    assign pre_wrap  = (pre_q == PW'(CM_CYCLES - 1));

    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        pre_d   = pre_q;
        cm_d    = cm_q;
        trig_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        dist_d  = dist_q;

        if (abort && (state_q != S_IDLE)) begin
            // Drop the attempt silently: no done pulse, and the previous
            // result stays visible.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // abort blocks only the automatic re-trigger, so a
                    // held abort cannot fire the sensor.
                    if (start || (cont_en && !abort)) begin
                        state_d = S_TRIG;
                        tmr_d   = '0;
                        trig_d  = 1'b1;
                    end
                end

                S_TRIG: begin
                    if (tmr_q == TW'(TRIG_CYC - 1)) begin
                        state_d = S_WAIT_RISE;
                        tmr_d   = '0;
                    end else begin
                        tmr_d  = tmr_q + 1'b1;
                        trig_d = 1'b1;
                    end
                end

                S_WAIT_RISE: begin
                    // A real edge is required, so an echo still high from
                    // the previous shot cannot start a measurement.
                    if (echo_rise) begin
                        state_d = S_MEASURE;
                        pre_d   = '0;
                        cm_d    = '0;
                    end else if (tmr_q == TW'(RISE_TO - 1)) begin
                        state_d = S_HOLDOFF;
                        tmr_d   = '0;
                        done_d  = 1'b1;
                        err_d   = ST_NO_ECHO;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end

                S_MEASURE: begin
                    // The fall edge is checked first. When the fall coincides
                    // with the wrap into over-range, the result is
                    // OK at MAX_CM.
                    if (fall_q) begin
                        state_d = S_HOLDOFF;
                        tmr_d   = '0;
                        done_d  = 1'b1;
                        err_d   = ST_OK;
                        dist_d  = DW'(cm_q);
                    end else if (pre_wrap) begin
                        pre_d = '0;
                        if (cm_q == CW'(MAX_CM)) begin
                            state_d = S_HOLDOFF;
                            tmr_d   = '0;
                            done_d  = 1'b1;
                            err_d   = ST_OVER;
                            dist_d  = DW'(MAX_CM);
                        end else begin
                            cm_d = cm_q + 1'b1;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end

                S_HOLDOFF: begin
                    if (tmr_q == TW'(HOLDOFF_CYC - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments. All flops then
    // update together from values sampled before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
            echo_d_q    <= 1'b0;
            fall_q      <= 1'b0;
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            pre_q       <= '0;
            cm_q        <= '0;
            trig_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= ST_OK;
            dist_q      <= '0;
        end else begin
            echo_meta_q <= echo;
            echo_s_q    <= echo_meta_q;
            echo_d_q    <= echo_s_q;
            fall_q      <= fall_d;
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            pre_q       <= pre_d;
            cm_q        <= cm_d;
            trig_q      <= trig_d;
            done_q      <= done_d;
            err_q       <= err_d;
            dist_q      <= dist_d;
        end
    end

    assign trig    = trig_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign dist_cm = dist_q;

endmodule

// File: tb/tb_ultra_meas_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ultra_meas_ctrl
//
// Directed bench for ultra_meas_ctrl, built with small timing parameters.
// A table of single shots lists the echo delay after trig falls, the echo
// width, and the expected status, distance and done latency. Each shot is
// counted from the cycle in which trig falls. Hand-written sequences then
// cover async reset, continuous mode and abort.
// ----------------------------------------------------------------------------
module tb_ultra_meas_ctrl;

    localparam int TRIG_CYC    = 3;
    localparam int CM_CYCLES   = 4;
    localparam int RISE_TO     = 20;
    localparam int MAX_CM      = 10;
    localparam int HOLDOFF_CYC = 8;
    localparam int DW          = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          cont_en;
    logic          abort;
    logic          echo;
    logic          trig;
    logic          busy;
    logic          done;
    logic [1:0]    err;
    logic [DW-1:0] dist_cm;

    int pass_cnt = 0;
    int total_cnt = 0;

    ultra_meas_ctrl #(
        .TRIG_CYC   (TRIG_CYC),
        .CM_CYCLES  (CM_CYCLES),
        .RISE_TO    (RISE_TO),
        .MAX_CM     (MAX_CM),
        .HOLDOFF_CYC(HOLDOFF_CYC),
        .DW         (DW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cont_en(cont_en),
        .abort  (abort),
        .echo   (echo),
        .trig   (trig),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .dist_cm(dist_cm)
    );

    always #5 clk = ~clk;

    typedef struct {
        int delay;     // cycles after trig falls before echo rises
        int width;     // echo high cycles, 0 = never rises
        int exp_err;
        int exp_dist;
        int exp_lat;   // cycles from trig fall to done
    } shot_t;

    shot_t shots[10];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 300) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_shot(input shot_t s, input int idx);
        int n;
        int lat;
        int hold;
        int extra;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (trig && n < 20) begin
            n++;
            tick();
        end
        check($sformatf("shot%0d_trig_width", idx), n, TRIG_CYC);
        lat   = 0;
        hold  = 0;
        extra = 0;
        fork
            begin
                repeat (s.delay) tick();
                if (s.width > 0) begin
                    echo = 1'b1;
                    repeat (s.width) tick();
                    echo = 1'b0;
                end
            end
            begin
                while (!done && lat < 200) begin
                    tick();
                    lat++;
                end
                check($sformatf("shot%0d_done_latency", idx), lat, s.exp_lat);
                check($sformatf("shot%0d_err", idx), int'(err), s.exp_err);
                check($sformatf("shot%0d_dist", idx), int'(dist_cm), s.exp_dist);
                while (busy && hold < 50) begin
                    tick();
                    hold++;
                    if (done) extra++;
                end
                check($sformatf("shot%0d_holdoff", idx), hold, HOLDOFF_CYC);
            end
        join
        repeat (10) begin
            tick();
            if (done) extra++;
        end
        check($sformatf("shot%0d_extra_done", idx), extra, 0);
    endtask

    initial begin
        int c;
        int bad;

        //           delay width err dist lat
        shots[0] = '{5,  22,   0,  5,  31};  // nominal: 22 cycles -> 5 cm
        shots[1] = '{3,  0,    1,  5,  20};  // no echo, distance kept
        shots[2] = '{2,  60,   2,  10, 49};  // over-range on 11th wrap
        shots[3] = '{1,  8,    0,  2,  13};
        shots[4] = '{0,  13,   0,  3,  17};  // echo rises as trig falls
        shots[5] = '{4,  43,   0,  10, 51};  // fall with over-range wrap: fall wins
        shots[6] = '{17, 8,    0,  2,  29};  // rise on the last wait cycle
        shots[7] = '{18, 8,    1,  2,  20};  // rise one cycle too late
        shots[8] = '{2,  3,    0,  0,  9};   // shorter than 1 cm
        shots[9] = '{6,  44,   2,  10, 53};  // first width that is over-range

        rst = 1'b1; start = 1'b0; cont_en = 1'b0; abort = 1'b0; echo = 1'b0;
        #2;
        check("rst_trig", int'(trig), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err",  int'(err), 0);
        check("rst_dist", int'(dist_cm), 0);
        #10 rst = 1'b0;
        tick();
        check("post_rst_busy", int'(busy), 0);

        foreach (shots[i]) run_shot(shots[i], i);

        // Continuous mode: back-to-back 8-cycle echoes.
        cont_en = 1'b1;
        tick();
        check("cont_a_trig_rise", int'(trig), 1);
        repeat (TRIG_CYC) tick();
        check("cont_a_trig_fall", int'(trig), 0);
        repeat (2) tick();
        echo = 1'b1;
        repeat (8) tick();
        echo = 1'b0;
        wait_done(c);
        check("cont_a_fall_to_done", c, 4);
        check("cont_a_dist", int'(dist_cm), 2);
        check("cont_a_err", int'(err), 0);
        c = 0;
        while (!trig && c < 50) begin
            tick();
            c++;
        end
        check("cont_period_gap", c, HOLDOFF_CYC + 1);
        repeat (TRIG_CYC) tick();
        repeat (2) tick();
        echo = 1'b1;
        repeat (5) tick();
        cont_en = 1'b0;               // dropped mid-MEASURE
        repeat (3) tick();
        echo = 1'b0;
        wait_done(c);
        check("cont_b_fall_to_done", c, 4);
        check("cont_b_dist", int'(dist_cm), 2);
        tick();
        start = 1'b1;                 // ignored while busy
        tick();
        start = 1'b0;
        c = 2;
        while (busy && c < 50) begin
            tick();
            c++;
        end
        check("cont_b_holdoff", c, HOLDOFF_CYC);
        bad = 0;
        repeat (20) begin
            tick();
            if (trig || busy) bad++;
        end
        check("cont_stop_stays_idle", bad, 0);

        // Abort during MEASURE.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (TRIG_CYC) tick();
        tick();
        echo = 1'b1;
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_trig", int'(trig), 0);
        check("abort_done", int'(done), 0);
        bad = 0;
        repeat (10) begin
            tick();
            if (done) bad++;
        end
        echo = 1'b0;
        repeat (15) begin
            tick();
            if (done || busy) bad++;
        end
        check("abort_no_done", bad, 0);
        check("abort_dist_kept", int'(dist_cm), 2);
        check("abort_err_kept", int'(err), 0);

        // abort held together with cont_en in IDLE blocks the trigger.
        abort = 1'b1;
        cont_en = 1'b1;
        bad = 0;
        repeat (10) begin
            tick();
            if (trig || busy) bad++;
        end
        check("abort_cont_blocked", bad, 0);
        abort = 1'b0;
        tick();
        check("abort_release_trig", int'(trig), 1);
        cont_en = 1'b0;
        abort = 1'b1;                 // abort during TRIG
        tick();
        abort = 1'b0;
        check("abort_trig_busy", int'(busy), 0);
        check("abort_trig_trig", int'(trig), 0);

        // Async reset in the middle of TRIG, between clock edges.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_rst_trig", int'(trig), 1);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_trig", int'(trig), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_err",  int'(err), 0);
        check("mid_rst_dist", int'(dist_cm), 0);
        #2 rst = 1'b0;
        tick();
        tick();
        check("mid_rst_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ultra_meas_ctrl.md
Name: ultra_meas_ctrl

Overview:
- Measurement sequencer for the HC-SR04-style ultrasonic ranging path.
- Issues the trigger pulse, waits for the echo, times the echo high width in whole centimetres, and enforces the sensor's inter-shot hold-off.
- Supports single-shot and continuous modes; reports a binary distance plus a status code to the display/BCD stage.
- Sits between the sensor pins and the display conversion logic, replacing free-running trigger generation with a controlled, timeout-protected sequence.

Parameters:
- TRIG_CYC, 270: trigger high width in clk cycles (10 us at 27 MHz).
- CM_CYCLES, 1566: clk cycles per centimetre of distance (27 x 58).
- RISE_TO, 810000: max clk cycles waiting for echo rise after trig falls (30 ms).
- MAX_CM, 400: largest reportable distance; longer echoes are over-range.
- HOLDOFF_CYC, 1620000: clk cycles from leaving measurement to next permitted trigger (60 ms).
- DW, 10: width of dist_cm; must hold MAX_CM.

Ports:
- clk, input, 1: system clock, 27 MHz.
- rst, input, 1: asynchronous active-high reset.
- start, input, 1: one-shot request, sampled in IDLE only.
- cont_en, input, 1: continuous mode; while high, IDLE re-triggers automatically.
- abort, input, 1: synchronous abort of the current sequence.
- echo, input, 1: raw sensor echo pin (asynchronous).
- trig, output, 1: sensor trigger, registered.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse at the end of every measurement attempt.
- err, output, 2: status latched with done. 00 = OK, 01 = NO_ECHO, 10 = OVER_RANGE.
- dist_cm, output, DW: last distance in cm, held until next update.

Behaviour:
- Reset (async, rst=1): state IDLE; trig, busy, and done = 0; err = 00; dist_cm = 0; all counters and sync flops = 0.
- Echo synchroniser: 2-FF sync to echo_s; echo_d = echo_s delayed 1 cycle.
  - rise = echo_s & ~echo_d
  - fall = ~echo_s & echo_d
- IDLE:
  - If start | cont_en, go to TRIG next cycle.
  - start pulses received while busy are ignored, not queued.
- TRIG:
  - trig = 1 for exactly TRIG_CYC cycles; first high cycle is the first cycle in TRIG.
  - Then trig = 0 and go to WAIT_RISE.
- WAIT_RISE:
  - Timer counts cycles in state.
  - On rise: go to MEASURE; clear prescaler and cm_cnt.
  - If timer reaches RISE_TO without rise: done = 1, err = 01, dist_cm unchanged, go to HOLDOFF.
- MEASURE:
  - Prescaler counts 0..CM_CYCLES-1; on wrap, cm_cnt increments. Partial centimetres are truncated.
  - On fall: dist_cm = cm_cnt, err = 00, done = 1, go to HOLDOFF.
  - If the prescaler wraps while cm_cnt == MAX_CM: dist_cm = MAX_CM, err = 10, done = 1, go to HOLDOFF.
  - If fall and over-range occur in the same cycle, fall wins (OK, dist_cm = MAX_CM).
- HOLDOFF:
  - Counts HOLDOFF_CYC cycles, then goes to IDLE; echo is ignored.
  - A lingering echo high does not produce a false rise next shot, because WAIT_RISE requires an edge.
- done and err are registered together; done is high for exactly 1 cycle per attempt. err holds its value until the next done.
- Latency: echo pin fall to done high = 4 clk cycles (2 sync + 1 edge + 1 output register).
- abort (any non-IDLE state):
  - Next cycle: state IDLE, trig = 0, no done, err and dist_cm unchanged.
  - abort in IDLE has no effect.
  - If abort and cont_en are both high in IDLE, no trigger is issued while abort is high.
- Continuous mode:
  - Shot period = TRIG_CYC + echo wait/measure time + HOLDOFF_CYC + 1 IDLE cycle.
  - Clearing cont_en mid-shot completes the current shot, then stays in IDLE.
- Counter widths are sized by $clog2 of their respective maxima; there is no wrap-around in any counter.

Test Plan (TRIG_CYC=3, CM_CYCLES=4, RISE_TO=20, MAX_CM=10, HOLDOFF_CYC=8, DW=4):
1. Reset async mid-TRIG: assert rst between clk edges -> trig, busy, done, err, dist_cm all 0 immediately; IDLE after release.
2. start pulse, echo high for 22 cycles, 5 cycles after trig falls -> trig high exactly 3 cycles; done pulse with err=00, dist_cm=5; done 4 cycles after echo falls; busy low 8 cycles after done.
3. start, echo never rises -> done at 20 cycles after trig falls, err=01, dist_cm keeps its previous value; then HOLDOFF 8 cycles.
4. echo held high for 60 cycles -> done with err=10, dist_cm=10 after the 11th prescaler wrap; echo fall during HOLDOFF produces no second done.
5. cont_en=1 with 8-cycle echoes -> back-to-back shots each giving dist_cm=2; start pulses during busy are ignored; cont_en dropped mid-MEASURE -> shot completes, then IDLE.
6. abort during MEASURE -> IDLE next cycle, trig=0, no done, dist_cm unchanged; abort+cont_en held in IDLE -> no trig until abort falls.
